frame_parse_rx: RTL and testbench



---
 rtl/frame_pkg.sv | 27 ++
 rtl/frame_cfg_sync.sv | 53 +++++
 rtl/frame_parse_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_frame_parse_rx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the frame generator / frame receiver pair:
// FSM encoding, scramble ROM wrap point and length-halving helpers.
package frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        HEAD = 2'd2,
        DATA = 2'd3
    } frame_state_t;

    localparam int SCR_LAST     = 254;
    localparam int SCR_ADDR_W   = 11;
    localparam int HEAD_WORDS_W = 7;
    localparam int DAT_WORDS_W  = 15;
    localparam int CNT_W        = DAT_WORDS_W;

    // Byte lengths are converted to 16-bit word counts by dropping the LSB.
    function automatic logic [HEAD_WORDS_W-1:0] half8(input logic [7:0] bytes);
        return bytes[7:1];
    endfunction

    function automatic logic [DAT_WORDS_W-1:0] half16(input logic [15:0] bytes);
        return bytes[15:1];
    endfunction

endpackage

// File: rtl/frame_cfg_sync.sv
// update_flag two-flop synchronizer with rising-edge config latch.
// Shared by the frame generator and the frame receiver.
module frame_cfg_sync
    import frame_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    update_flag,
    input  logic [15:0]             dat_length,
    input  logic [7:0]              head_length,
    input  logic [7:0]              unscr_length,
    input  logic                    scr_choose,
    output logic                    f0,
    output logic                    f1,
    output logic                    cfg_latch,
    output logic [DAT_WORDS_W-1:0]  dat_words,
    output logic [HEAD_WORDS_W-1:0] head_words,
    output logic [HEAD_WORDS_W-1:0] unscr_words,
    output logic                    scr_en,
    output logic                    cfg_err
);

    logic unused_lsbs;

    assign cfg_latch   = f0 & ~f1;
    assign unused_lsbs = dat_length[0] ^ head_length[0] ^ unscr_length[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            f0          <= 1'b0;
            f1          <= 1'b0;
            dat_words   <= '0;
            head_words  <= '0;
            unscr_words <= '0;
            scr_en      <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            f0 <= update_flag;
            f1 <= f0;
            if (cfg_latch) begin
                dat_words   <= half16(dat_length);
                head_words  <= half8(head_length);
                unscr_words <= half8(unscr_length);
                scr_en      <= scr_choose;
                // Validity is judged once, at latch time, from the incoming lengths.
                cfg_err     <= (half8(head_length) == '0) ||
                               (half16(dat_length) == '0) ||
                               (half8(unscr_length) > half8(head_length));
            end
        end
    end

endmodule

// File: rtl/frame_parse_rx.sv
// Frame receiver: sync hunt, head/data split, descramble, two-stage output.
// Optional macro RX_SYNC_ERR_CNT_EN adds the sync_err_cnt discard counter.
module frame_parse_rx
    import frame_pkg::*;
#(
    parameter int SCR_LAST = frame_pkg::SCR_LAST
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  update_flag,
    input  logic [15:0]           dat_length,
    input  logic [7:0]            head_length,
    input  logic [7:0]            unscr_length,
    input  logic                  scr_choose,
    input  logic [15:0]           sync_word,
    input  logic                  en_in,
    input  logic [15:0]           dat_in,
    output logic [SCR_ADDR_W-1:0] addr_scr,
    input  logic [15:0]           scr_dbin,
    output logic                  head_wreq,
    output logic [15:0]           head_out,
    output logic                  dat_wreq,
    output logic [15:0]           dat_out,
    input  logic                  head_full,
    input  logic                  dat_full,
    output logic                  frame_done,
    output logic                  cfg_err,
`ifdef RX_SYNC_ERR_CNT_EN
    output logic [15:0]           sync_err_cnt,
`endif
    output logic                  ovf
);

    localparam logic [SCR_ADDR_W-1:0] K_LAST = SCR_ADDR_W'(SCR_LAST);

    logic                    f0;
    logic                    f1;
    logic                    cfg_latch;
    logic [DAT_WORDS_W-1:0]  dat_words;
    logic [HEAD_WORDS_W-1:0] head_words;
    logic [HEAD_WORDS_W-1:0] unscr_words;
    logic                    scr_en;

    frame_cfg_sync u_cfg_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .update_flag (update_flag),
        .dat_length  (dat_length),
        .head_length (head_length),
        .unscr_length(unscr_length),
        .scr_choose  (scr_choose),
        .f0          (f0),
        .f1          (f1),
        .cfg_latch   (cfg_latch),
        .dat_words   (dat_words),
        .head_words  (head_words),
        .unscr_words (unscr_words),
        .scr_en      (scr_en),
        .cfg_err     (cfg_err)
    );

    frame_state_t            state;
    frame_state_t            state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [SCR_ADDR_W-1:0]   k;
    logic [SCR_ADDR_W-1:0]   k_nxt;
    logic [SCR_ADDR_W-1:0]   k_cur;
    logic [SCR_ADDR_W-1:0]   k_step;
    logic [CNT_W-1:0]        head_ext;
    logic [CNT_W-1:0]        unscr_ext;
    logic                    take;
    logic                    take_head;
    logic                    take_scr;
    logic                    take_last;
    logic                    hunt_miss;

    logic                    s1_valid;
    logic                    s1_head;
    logic                    s1_scr;
    logic                    s1_last;
    logic [15:0]             s1_raw;
    logic [15:0]             s1_word;

    assign head_ext  = CNT_W'(head_words);
    assign unscr_ext = CNT_W'(unscr_words);
    // A sync hit restarts the scramble sequence, so HUNT always indexes from 0.
    assign k_cur     = (state == HUNT) ? '0 : k;
    assign k_step    = (k_cur == K_LAST) ? '0 : k_cur + 1'b1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        k_nxt     = k;
        take      = 1'b0;
        take_head = 1'b0;
        take_scr  = 1'b0;
        take_last = 1'b0;
        hunt_miss = 1'b0;
        if (f0) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            k_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (f1 && !cfg_err) state_nxt = HUNT;
                end
                HUNT: begin
                    if (en_in) begin
                        if (dat_in == sync_word) begin
                            take      = 1'b1;
                            take_head = 1'b1;
                            take_scr  = scr_en && (unscr_words == '0);
                            k_nxt     = take_scr ? k_step : '0;
                            if (head_words == HEAD_WORDS_W'(1)) begin
                                state_nxt = DATA;
                                cnt_nxt   = '0;
                            end else begin
                                state_nxt = HEAD;
                                cnt_nxt   = CNT_W'(1);
                            end
                        end else begin
                            hunt_miss = 1'b1;
                        end
                    end
                end
                HEAD: begin
                    if (en_in) begin
                        take      = 1'b1;
                        take_head = 1'b1;
                        take_scr  = scr_en && (cnt >= unscr_ext);
                        if (take_scr) k_nxt = k_step;
                        if (cnt == head_ext - 1'b1) begin
                            state_nxt = DATA;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (en_in) begin
                        take     = 1'b1;
                        take_scr = scr_en;
                        if (take_scr) k_nxt = k_step;
                        if (cnt == dat_words - 1'b1) begin
                            take_last = 1'b1;
                            state_nxt = HUNT;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage 1: classify the word and present the ROM address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            k        <= '0;
            addr_scr <= '0;
            s1_valid <= 1'b0;
            s1_head  <= 1'b0;
            s1_scr   <= 1'b0;
            s1_last  <= 1'b0;
            s1_raw   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            k        <= k_nxt;
            s1_valid <= take;
            s1_head  <= take_head;
            s1_scr   <= take_scr;
            s1_last  <= take_last;
            s1_raw   <= dat_in;
            if (take_scr) addr_scr <= k_cur;
        end
    end

    assign s1_word = s1_scr ? (s1_raw ^ scr_dbin) : s1_raw;

    // Stage 2: descramble and write; a full FIFO drops the word but not the frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_wreq  <= 1'b0;
            dat_wreq   <= 1'b0;
            head_out   <= '0;
            dat_out    <= '0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            head_wreq  <= s1_valid & s1_head & ~head_full;
            dat_wreq   <= s1_valid & ~s1_head & ~dat_full;
            frame_done <= s1_valid & s1_last;
            if (s1_valid && s1_head) head_out <= s1_word;
            if (s1_valid && !s1_head) dat_out <= s1_word;
            if (s1_valid && ((s1_head && head_full) || (!s1_head && dat_full))) begin
                ovf <= 1'b1;
            end else if (cfg_latch) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef RX_SYNC_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n || cfg_latch) begin
            sync_err_cnt <= '0;
        end else if (hunt_miss && (sync_err_cnt != 16'hFFFF)) begin
            sync_err_cnt <= sync_err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_parse_rx.sv
// Bench for frame_parse_rx: word-level frame model, scoreboard queues and
// directed frames covering plain, descrambled, wrap, hunt, gaps/full and config cases.
module tb_frame_parse_rx;

    logic        clk;
    logic        reset_n;
    logic        update_flag;
    logic [15:0] dat_length;
    logic [7:0]  head_length;
    logic [7:0]  unscr_length;
    logic        scr_choose;
    logic [15:0] sync_word;
    logic        en_in;
    logic [15:0] dat_in;
    logic [10:0] addr_scr;
    logic [15:0] scr_dbin;
    logic        head_wreq;
    logic [15:0] head_out;
    logic        dat_wreq;
    logic [15:0] dat_out;
    logic        head_full;
    logic        dat_full;
    logic        frame_done;
    logic        cfg_err;
    logic        ovf;
`ifdef RX_SYNC_ERR_CNT_EN
    logic [15:0] sync_err_cnt;
`endif

    frame_parse_rx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .update_flag (update_flag),
        .dat_length  (dat_length),
        .head_length (head_length),
        .unscr_length(unscr_length),
        .scr_choose  (scr_choose),
        .sync_word   (sync_word),
        .en_in       (en_in),
        .dat_in      (dat_in),
        .addr_scr    (addr_scr),
        .scr_dbin    (scr_dbin),
        .head_wreq   (head_wreq),
        .head_out    (head_out),
        .dat_wreq    (dat_wreq),
        .dat_out     (dat_out),
        .head_full   (head_full),
        .dat_full    (dat_full),
        .frame_done  (frame_done),
        .cfg_err     (cfg_err),
`ifdef RX_SYNC_ERR_CNT_EN
        .sync_err_cnt(sync_err_cnt),
`endif
        .ovf         (ovf)
    );

    // ---------------- clock / ROM ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rom [0:254];
    assign scr_dbin = (addr_scr <= 11'd254) ? rom[addr_scr[7:0]] : 16'h0000;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [15:0] head_exp_q[$];
    logic [16:0] dat_exp_q[$];   // bit 16 marks the last word of a frame
    int          exp_done = 0;
    int          got_done = 0;

    int          m_hw, m_dw, m_uw, pos, mk, m_sync_err;
    bit          m_scr, m_active;
    logic [15:0] m_sync;
    bit          pend;
    logic [10:0] pend_addr;
    bit          full_next;
    logic [16:0] dat_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Frame model: position within the frame decides head/data, scrambling and last.
    task automatic model_word(input logic [15:0] raw, input bit drop);
        logic [15:0] val;
        bit          scr;
        bit          last;
        if (!m_active) return;
        if (pos < 0) begin
            if (raw != m_sync) begin
                m_sync_err++;
                return;
            end
            pos = 0;
            mk  = 0;
        end
        scr = m_scr && (pos >= m_uw);
        val = raw;
        if (scr) begin
            val       = raw ^ rom[mk];
            pend      = 1'b1;
            pend_addr = 11'(mk);
            mk        = (mk == 254) ? 0 : mk + 1;
        end
        last = (pos == m_hw + m_dw - 1);
        if (pos < m_hw) head_exp_q.push_back(val);
        else if (!drop) dat_exp_q.push_back({last, val});
        if (last) begin
            exp_done++;
            pos = -1;
        end else begin
            pos++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic prelude();
        if (pend) begin
            check("addr_scr", 32'(addr_scr), 32'(pend_addr));
            pend = 1'b0;
        end
        dat_full  = full_next;
        full_next = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input bit drop = 1'b0);
        @(negedge clk);
        prelude();
        en_in     = 1'b1;
        dat_in    = w;
        full_next = drop;
        model_word(w, drop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            prelude();
            en_in = 1'b0;
        end
    endtask

    task automatic load_cfg(input logic [7:0] hl, input logic [7:0] ul, input logic [15:0] dl,
                            input bit scr, input logic [15:0] sw);
        bit err;
        @(negedge clk);
        prelude();
        en_in        = 1'b0;
        head_length  = hl;
        unscr_length = ul;
        dat_length   = dl;
        scr_choose   = scr;
        sync_word    = sw;
        update_flag  = 1'b1;
        m_active     = 1'b0;
        idle(3);
        update_flag = 1'b0;
        idle(3);
        err = (hl[7:1] == 0) || (dl[15:1] == 0) || (ul[7:1] > hl[7:1]);
        check("cfg_err", 32'(cfg_err), 32'(err));
        check("ovf_cleared", 32'(ovf), 32'd0);
        m_hw       = int'(hl[7:1]);
        m_uw       = int'(ul[7:1]);
        m_dw       = int'(dl[15:1]);
        m_scr      = scr;
        m_sync     = sw;
        m_active   = !err;
        pos        = -1;
        mk         = 0;
        m_sync_err = 0;
    endtask

    task automatic end_test(input string name);
        idle(4);
        check({name, "_head_q_empty"}, 32'(head_exp_q.size()), 32'd0);
        check({name, "_dat_q_empty"}, 32'(dat_exp_q.size()), 32'd0);
        check({name, "_frame_count"}, 32'(got_done), 32'(exp_done));
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (head_wreq) begin
            check("head_wreq_expected", 32'(head_exp_q.size() != 0), 32'd1);
            if (head_exp_q.size() != 0) check("head_out", 32'(head_out), 32'(head_exp_q.pop_front()));
        end
        if (dat_wreq) begin
            check("dat_wreq_expected", 32'(dat_exp_q.size() != 0), 32'd1);
            if (dat_exp_q.size() != 0) begin
                dat_e = dat_exp_q.pop_front();
                check("dat_out", 32'(dat_out), 32'(dat_e[15:0]));
                check("frame_done_align", 32'(frame_done), 32'(dat_e[16]));
            end
        end
        if (frame_done) begin
            check("frame_done_with_wreq", 32'(dat_wreq), 32'd1);
            got_done++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 255; i++) rom[i] = 16'(i * 16'h1357) ^ 16'h5A00;
        reset_n = 1'b0; update_flag = 1'b0; dat_length = '0; head_length = '0;
        unscr_length = '0; scr_choose = 1'b0; sync_word = 16'hEB90; en_in = 1'b0;
        dat_in = '0; head_full = 1'b0; dat_full = 1'b0;
        pend = 1'b0; full_next = 1'b0; m_active = 1'b0; pos = -1; mk = 0; m_sync_err = 0;
        m_hw = 0; m_dw = 0; m_uw = 0; m_scr = 1'b0; m_sync = 16'hEB90;

        // Reset state
        idle(3);
        check("rst_addr_scr", 32'(addr_scr), 32'd0);
        check("rst_head_wreq", 32'(head_wreq), 32'd0);
        check("rst_dat_wreq", 32'(dat_wreq), 32'd0);
        check("rst_head_out", 32'(head_out), 32'd0);
        check("rst_dat_out", 32'(dat_out), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Unscrambled frame with hand-pinned latency
        load_cfg(8'd8, 8'd8, 16'd8, 1'b0, 16'hEB90);
        send(16'hEB90); send(16'h0001); send(16'h0002); send(16'h0003);
        send(16'h0004); send(16'h0005); send(16'h0006); send(16'h0007);
        idle(1);
        check("t1_done_early", 32'(frame_done), 32'd0);
        idle(1);
        check("t1_done_lat2", 32'(frame_done), 32'd1);
        check("t1_dat_out_last", 32'(dat_out), 32'h0007);
        check("t1_head_out_last", 32'(head_out), 32'h0003);
        end_test("plain");

        // Descrambling
        load_cfg(8'd8, 8'd4, 16'd4, 1'b1, 16'hEB90);
        send(16'hEB90); send(16'h1111); send(16'h2222); send(16'h3333);
        send(16'hAAAA); send(16'hBBBB);
        idle(2);
        check("t2_head_out_last", 32'(head_out), 32'h7A64);
        check("t2_dat_out_last", 32'(dat_out), 32'hDBBE);
        check("t2_addr_last", 32'(addr_scr), 32'd3);
        end_test("descr");

        // Scramble address wrap over 300 data words
        load_cfg(8'd2, 8'd2, 16'd600, 1'b1, 16'hEB90);
        send(16'hEB90);
        for (int i = 0; i < 300; i++) send(16'(i * 3 + 7));
        idle(2);
        check("t3_addr_final", 32'(addr_scr), 32'd44);
        end_test("wrap");

        // Hunt past garbage
        load_cfg(8'd8, 8'd8, 16'd8, 1'b0, 16'hEB90);
        send(16'h1234); send(16'hEB91); send(16'h0000);
        send(16'hEB90); send(16'h0011); send(16'h0022); send(16'h0033);
        send(16'h0044); send(16'h0055); send(16'h0066); send(16'h0077);
`ifdef RX_SYNC_ERR_CNT_EN
        idle(1);
        check("t4_sync_err_cnt", 32'(sync_err_cnt), 32'(m_sync_err));
        check("t4_sync_err_cnt_lit", 32'(sync_err_cnt), 32'd3);
`endif
        end_test("hunt");

        // Gaps plus data FIFO full on data word 1
        send(16'hEB90); idle(1); send(16'h0101); idle(1);
        send(16'h0202); idle(1); send(16'h0303); idle(1);
        send(16'h0404); idle(1); send(16'h0505, 1'b1); idle(1);
        send(16'h0606); idle(1); send(16'h0707);
        idle(2);
        check("t5_ovf", 32'(ovf), 32'd1);
        check("t5_dat_out_last", 32'(dat_out), 32'h0707);
        end_test("gaps_full");

        // Invalid config, then mid-frame update
        load_cfg(8'd0, 8'd0, 16'd8, 1'b0, 16'hEB90);
        send(16'hEB90); send(16'h0001); send(16'h0002); send(16'h0003);
        send(16'h0004); send(16'h0005); send(16'h0006); send(16'h0007);
        end_test("cfg_invalid");
        load_cfg(8'd8, 8'd8, 16'd8, 1'b0, 16'hEB90);
        send(16'hEB90); send(16'h00A1); send(16'h00A2);
        load_cfg(8'd8, 8'd8, 16'd8, 1'b0, 16'hEB90);
        send(16'hEB90); send(16'h00B1); send(16'h00B2); send(16'h00B3);
        send(16'h00B4); send(16'h00B5); send(16'h00B6); send(16'h00B7);
        idle(2);
        check("t6_dat_out_last", 32'(dat_out), 32'h00B7);
        end_test("mid_update");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
